npc_ras: RTL and testbench
==========================

NPC_RAS -- requirements
Module: npc_ras

Interface
REQ-001 SHALL provide parameter RAS_DEPTH, default 8, return-address-stack entries (power of two, 2..64).
REQ-002 SHALL provide parameter EXC_VEC, default 32'hBFC0_0380, exception/TLB-refill entry address.
REQ-003 SHALL provide parameter ERET_OFS, default 32'd4, offset added to EPC on eret.
REQ-004 clk  in  1  sole clock; all state rises on posedge clk.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 PCWr  in  1  PC write enable (0 = front end stalled).
REQ-007 NPCOp  in  2  00 seq, 01 branch, 10 jump, 11 jump-register return.
REQ-008 PC, PF_PC, ret_addr, EPC  in  32 each  delay-slot PC, prefetch PC, register target, exception PC.
REQ-009 Imm  in  26  jump index / branch offset in [15:0].
REQ-010 link  in  1  current control transfer writes $31 (call).
REQ-011 MEM_eret_flush, MEM_ex  in  1 each  eret / exception from MEM.
REQ-012 NPC  out  32  next fetch address.
REQ-013 IF_Flush, ID_Flush, EX_Flush, MEM1_Flush, PF_Flush  out  1 each  stage flushes.
REQ-014 ras_top  out  32  predicted return address; ras_valid  out  1  stack non-empty.
REQ-015 ras_mispred  out  1  registered return-mispredict pulse; redirect_pending  out  1  latched redirect waiting.
REQ-016 redirect_cnt, mispred_cnt  out  32 each  performance counters (REQ-034).

Function
REQ-017 Raw targets SHALL be: seq PF_PC+4; branch PC+{sign-ext Imm[15:0],2'b00}; jump {PC[31:28],Imm[25:0],2'b00}; return ret_addr; mod 2^32.
REQ-018 NPC priority SHALL be: MEM_eret_flush -> EPC+ERET_OFS; else MEM_ex -> EXC_VEC; else redirect_pending -> pend_q; else raw target per NPCOp.
REQ-019 IF/ID/EX/MEM1_Flush SHALL equal MEM_eret_flush|MEM_ex, combinational, same cycle.
REQ-020 PF_Flush SHALL equal ((NPCOp!=00)&PCWr) | MEM_eret_flush | MEM_ex | redirect_pending.
REQ-021 If MEM_eret_flush or MEM_ex is high while PCWr=0, the selected target SHALL be latched into pend_q and redirect_pending set next cycle.
REQ-022 redirect_pending SHALL clear on the edge ending the first cycle with PCWr=1; a new eret/ex while pending SHALL overwrite pend_q (eret over ex).
REQ-023 RAS SHALL be circular: pointer sp (log2 RAS_DEPTH bits), count 0..RAS_DEPTH; ras_top = entry[sp-1], ras_valid = (count!=0).
REQ-024 Push SHALL occur when PCWr & link & NPCOp!=00 & no eret/ex & !redirect_pending, writing PC+4 (address after delay slot).
REQ-025 Pop SHALL occur when PCWr & NPCOp==11 & count!=0 & no eret/ex & !redirect_pending.
REQ-026 Push on full SHALL overwrite oldest entry, sp wraps, count stays RAS_DEPTH.
REQ-027 Pop on empty SHALL not change state; ras_mispred stays 0.
REQ-028 Simultaneous push and pop SHALL replace top with PC+4; sp and count unchanged.
REQ-029 On each pop, ras_mispred SHALL be 1 for exactly the next cycle iff ras_top != ret_addr.
REQ-030 eret/ex SHALL not modify RAS contents, sp or count.

Reset
REQ-031 rstn low SHALL immediately clear sp, count, redirect_pending, pend_q, ras_mispred and both counters; entries need not clear.
REQ-032 Reset mid-pending SHALL drop the pending redirect; NPC after release follows REQ-018 inputs.
REQ-033 Combinational outputs SHALL follow inputs during reset with redirect_pending=0, ras_valid=0.

Configuration
REQ-034 With NPC_PERF_CNT_EN defined: redirect_cnt increments each cycle PF_Flush&PCWr, mispred_cnt each ras_mispred cycle, both wrapping at 2^32; undefined: both ports tied 0, no counter flops.

Verification
REQ-035 NPCOp=01, PC=0x8000_0010, Imm[15:0]=0xFFFE, PCWr=1 -> NPC=0x8000_0008, PF_Flush=1, stage flushes 0.
REQ-036 MEM_ex=1, PCWr=0, next 2 cycles PCWr=0 then 1 -> redirect_pending=1, NPC=0xBFC0_0380 throughout, clears after PCWr cycle.
REQ-037 Push 9 calls PC=0x100..0x900 step 0x100 (depth 8), then 8 pops -> ras_top 0x904 down to 0x204, ras_valid 0 after 8th pop.
REQ-038 Push PC=0x400, pop with ret_addr=0x500 -> NPC=0x500, ras_mispred=1 one cycle; mispred_cnt=1 with NPC_PERF_CNT_EN.
REQ-039 MEM_eret_flush & MEM_ex together, EPC=0x8000_1000 -> NPC=0x8000_1004, all flushes 1, RAS unchanged.
REQ-040 rstn low while redirect_pending=1 and count=3 -> pending 0, ras_valid 0 immediately, counters 0.

Source files
------------

// File: rtl/npc_ras_if.sv
// Next-PC / return-address-stack bundle: front-end control inputs and redirect/prediction outputs.
// Combinational signals only; this interface has no latency and no backpressure of its own.
// The stall input PCWr is the only form of backpressure the block sees.
interface npc_ras_if;
    logic        PCWr;
    logic [1:0]  NPCOp;
    logic [31:0] PC;
    logic [31:0] PF_PC;
    logic [31:0] ret_addr;
    logic [31:0] EPC;
    logic [25:0] Imm;
    logic        link;
    logic        MEM_eret_flush;
    logic        MEM_ex;
    logic [31:0] NPC;
    logic        IF_Flush;
    logic        ID_Flush;
    logic        EX_Flush;
    logic        MEM1_Flush;
    logic        PF_Flush;
    logic [31:0] ras_top;
    logic        ras_valid;
    logic        ras_mispred;
    logic        redirect_pending;
    logic [31:0] redirect_cnt;
    logic [31:0] mispred_cnt;

    modport master (
        output PCWr, NPCOp, PC, PF_PC, ret_addr, EPC, Imm, link, MEM_eret_flush, MEM_ex,
        input  NPC, IF_Flush, ID_Flush, EX_Flush, MEM1_Flush, PF_Flush, ras_top, ras_valid,
               ras_mispred, redirect_pending, redirect_cnt, mispred_cnt
    );
    modport slave (
        input  PCWr, NPCOp, PC, PF_PC, ret_addr, EPC, Imm, link, MEM_eret_flush, MEM_ex,
        output NPC, IF_Flush, ID_Flush, EX_Flush, MEM1_Flush, PF_Flush, ras_top, ras_valid,
               ras_mispred, redirect_pending, redirect_cnt, mispred_cnt
    );
endinterface

// File: rtl/npc_ras.sv
// Next-PC select with exception redirect latch and circular return-address stack (opt. NPC_PERF_CNT_EN counters).
// NPC and flushes are combinational; ras_mispred and redirect_pending are registered (1 cycle).
// A redirect arriving while PCWr=0 is held in pend_q until the first cycle with PCWr=1.
module npc_ras #(
    parameter int          RAS_DEPTH = 8,
    parameter logic [31:0] EXC_VEC   = 32'hBFC0_0380,
    parameter logic [31:0] ERET_OFS  = 32'd4
) (
    input logic      clk,
    input logic      rstn,
    npc_ras_if.slave bus
);
    localparam int SPW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [SPW:0] FULL = (SPW+1)'(RAS_DEPTH);

    logic [31:0]    ras_mem [RAS_DEPTH];
    logic [SPW-1:0] sp;
    logic [SPW-1:0] wr_idx;
    logic [SPW:0]   count;
    logic [31:0]    pend_q;
    logic           pend;
    logic           mis_q;
    logic           exc;
    logic           push;
    logic           pop;
    logic [31:0]    exc_tgt;
    logic [31:0]    raw_tgt;
    logic [31:0]    link_addr;
    logic [31:0]    top;

    assign exc       = bus.MEM_eret_flush | bus.MEM_ex;
    assign exc_tgt   = bus.MEM_eret_flush ? (bus.EPC + ERET_OFS) : EXC_VEC;
    assign link_addr = bus.PC + 32'd4;
    assign top       = ras_mem[sp - 1'b1];

    always_comb begin
        raw_tgt = bus.PF_PC + 32'd4;
        case (bus.NPCOp)
            2'b01:   raw_tgt = bus.PC + {{14{bus.Imm[15]}}, bus.Imm[15:0], 2'b00};
            2'b10:   raw_tgt = {bus.PC[31:28], bus.Imm, 2'b00};
            2'b11:   raw_tgt = bus.ret_addr;
            default: raw_tgt = bus.PF_PC + 32'd4;
        endcase
    end

    // Stack updates are suppressed while a redirect is live or still pending.
    assign push   = bus.PCWr & bus.link & (bus.NPCOp != 2'b00) & ~exc & ~pend;
    assign pop    = bus.PCWr & (bus.NPCOp == 2'b11) & (count != '0) & ~exc & ~pend;
    assign wr_idx = pop ? (sp - 1'b1) : sp;

    assign bus.NPC              = exc ? exc_tgt : (pend ? pend_q : raw_tgt);
    assign bus.IF_Flush         = exc;
    assign bus.ID_Flush         = exc;
    assign bus.EX_Flush         = exc;
    assign bus.MEM1_Flush       = exc;
    assign bus.PF_Flush         = ((bus.NPCOp != 2'b00) & bus.PCWr) | exc | pend;
    assign bus.ras_top          = top;
    assign bus.ras_valid        = (count != '0);
    assign bus.ras_mispred      = mis_q;
    assign bus.redirect_pending = pend;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend   <= 1'b0;
            pend_q <= '0;
        end else if (exc && !bus.PCWr) begin
            pend   <= 1'b1;
            pend_q <= exc_tgt;
        end else if (bus.PCWr) begin
            pend   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sp    <= '0;
            count <= '0;
            mis_q <= 1'b0;
        end else begin
            mis_q <= pop && (top != bus.ret_addr);
            if (push && !pop) begin
                sp <= sp + 1'b1;
                if (count != FULL) count <= count + 1'b1;
            end else if (pop && !push) begin
                sp    <= sp - 1'b1;
                count <= count - 1'b1;
            end
        end
    end

    // Entries carry no reset; count gates every use of them.
    always_ff @(posedge clk) begin
        if (push) ras_mem[wr_idx] <= link_addr;
    end

`ifdef NPC_PERF_CNT_EN
    logic [31:0] rcnt_q;
    logic [31:0] mcnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rcnt_q <= '0;
            mcnt_q <= '0;
        end else begin
            if (bus.PF_Flush && bus.PCWr) rcnt_q <= rcnt_q + 32'd1;
            if (mis_q)                    mcnt_q <= mcnt_q + 32'd1;
        end
    end

    assign bus.redirect_cnt = rcnt_q;
    assign bus.mispred_cnt  = mcnt_q;
`else
    assign bus.redirect_cnt = '0;
    assign bus.mispred_cnt  = '0;
`endif
endmodule

// File: tb/tb_npc_ras.sv
// Scoreboard bench for npc_ras: a queue-based reference stack plus fixed vectors feed expectations,
// which are drained and compared at the negedge of each driven cycle.
module tb_npc_ras;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    npc_ras_if bus();
    npc_ras #(.RAS_DEPTH(8)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    localparam int I_NPC = 0, I_PFF = 1, I_STF = 2, I_TOP = 3, I_VLD = 4,
                   I_MIS = 5, I_PEND = 6, I_RCNT = 7, I_MCNT = 8;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] val;
    } exp_t;

    exp_t        sb [$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_stk [$];
    bit          m_pend;
    bit          m_mis;
    logic [31:0] m_pq;
    logic [31:0] m_rc;
    logic [31:0] m_mc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic string nm(input int id);
        case (id)
            I_NPC:   return "npc";
            I_PFF:   return "pf_flush";
            I_STF:   return "stage_flush";
            I_TOP:   return "ras_top";
            I_VLD:   return "ras_valid";
            I_MIS:   return "ras_mispred";
            I_PEND:  return "redirect_pending";
            I_RCNT:  return "redirect_cnt";
            default: return "mispred_cnt";
        endcase
    endfunction

    function automatic logic [31:0] obs(input int id);
        case (id)
            I_NPC:   return bus.NPC;
            I_PFF:   return {31'd0, bus.PF_Flush};
            I_STF:   return {28'd0, bus.IF_Flush, bus.ID_Flush, bus.EX_Flush, bus.MEM1_Flush};
            I_TOP:   return bus.ras_top;
            I_VLD:   return {31'd0, bus.ras_valid};
            I_MIS:   return {31'd0, bus.ras_mispred};
            I_PEND:  return {31'd0, bus.redirect_pending};
            I_RCNT:  return bus.redirect_cnt;
            default: return bus.mispred_cnt;
        endcase
    endfunction

    task automatic expect_val(input int id, input logic [31:0] v);
        exp_t e;
        e.id  = id[3:0];
        e.val = v;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] m_top();
        return (m_stk.size() != 0) ? m_stk[m_stk.size()-1] : 32'd0;
    endfunction

    function automatic logic [31:0] exc_target();
        return bus.MEM_eret_flush ? bus.EPC + 32'd4 : 32'hBFC0_0380;
    endfunction

    function automatic bit pf_expected();
        return (bus.NPCOp != 2'b00 && bus.PCWr) || bus.MEM_eret_flush || bus.MEM_ex || m_pend;
    endfunction

    task automatic model_reset();
        m_stk.delete();
        m_pend = 0; m_mis = 0; m_pq = 0; m_rc = 0; m_mc = 0;
    endtask

    task automatic model_expect();
        logic [31:0] raw;
        logic [31:0] boff;
        bit          exc;
        exc  = bus.MEM_eret_flush || bus.MEM_ex;
        boff = 32'($signed(bus.Imm[15:0])) << 2;
        case (bus.NPCOp)
            2'b00: raw = bus.PF_PC + 32'd4;
            2'b01: raw = bus.PC + boff;
            2'b10: raw = {bus.PC[31:28], bus.Imm, 2'b00};
            default: raw = bus.ret_addr;
        endcase
        expect_val(I_NPC, exc ? exc_target() : (m_pend ? m_pq : raw));
        expect_val(I_PFF, {31'd0, pf_expected()});
        expect_val(I_STF, exc ? 32'hF : 32'h0);
        expect_val(I_VLD, {31'd0, m_stk.size() != 0});
        if (m_stk.size() != 0) expect_val(I_TOP, m_top());
        expect_val(I_MIS, {31'd0, m_mis});
        expect_val(I_PEND, {31'd0, m_pend});
`ifdef NPC_PERF_CNT_EN
        expect_val(I_RCNT, m_rc);
        expect_val(I_MCNT, m_mc);
`else
        expect_val(I_RCNT, 32'd0);
        expect_val(I_MCNT, 32'd0);
`endif
    endtask

    task automatic model_edge();
        bit exc, psh, pp;
        exc = bus.MEM_eret_flush || bus.MEM_ex;
        psh = bus.PCWr && bus.link && bus.NPCOp != 2'b00 && !exc && !m_pend;
        pp  = bus.PCWr && bus.NPCOp == 2'b11 && m_stk.size() != 0 && !exc && !m_pend;
        if (pf_expected() && bus.PCWr) m_rc = m_rc + 32'd1;
        if (m_mis) m_mc = m_mc + 32'd1;
        m_mis = pp && (m_top() != bus.ret_addr);
        if (psh && pp) m_stk[m_stk.size()-1] = bus.PC + 32'd4;
        else if (psh) begin
            m_stk.push_back(bus.PC + 32'd4);
            if (m_stk.size() > 8) void'(m_stk.pop_front());
        end else if (pp) void'(m_stk.pop_back());
        if (exc && !bus.PCWr) begin
            m_pend = 1;
            m_pq   = exc_target();
        end else if (bus.PCWr) m_pend = 0;
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            check(nm(int'(e.id)), obs(int'(e.id)), e.val);
        end
    endtask

    task automatic step();
        model_expect();
        @(negedge clk);
        drain();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.PCWr = 1'b1; bus.NPCOp = 2'b00; bus.link = 1'b0;
        bus.MEM_eret_flush = 1'b0; bus.MEM_ex = 1'b0;
        bus.PC = 32'h0000_2000; bus.PF_PC = 32'h0000_1000; bus.Imm = '0;
        bus.ret_addr = '0; bus.EPC = '0;
    endtask

    task automatic call(input logic [31:0] pc);
        set_idle();
        bus.NPCOp = 2'b10; bus.link = 1'b1; bus.PC = pc;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        set_idle();
        model_reset();
        #2;
        expect_val(I_PEND, 32'd0);
        expect_val(I_VLD, 32'd0);
        expect_val(I_MIS, 32'd0);
        expect_val(I_RCNT, 32'd0);
        expect_val(I_MCNT, 32'd0);
        expect_val(I_NPC, 32'h0000_1004);
        drain();
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        // Backward branch.
        set_idle();
        bus.NPCOp = 2'b01; bus.PC = 32'h8000_0010; bus.Imm = 26'h000_FFFE;
        expect_val(I_NPC, 32'h8000_0008);
        expect_val(I_PFF, 32'd1);
        expect_val(I_STF, 32'd0);
        step();

        // Exception while stalled is held until the front end accepts it.
        set_idle();
        bus.MEM_ex = 1'b1; bus.PCWr = 1'b0;
        expect_val(I_NPC, 32'hBFC0_0380);
        step();
        set_idle(); bus.PCWr = 1'b0;
        expect_val(I_PEND, 32'd1); expect_val(I_NPC, 32'hBFC0_0380);
        step();
        set_idle();
        expect_val(I_PEND, 32'd1); expect_val(I_NPC, 32'hBFC0_0380);
        step();
        expect_val(I_PEND, 32'd0);
        step();

        // Overflow by one, then drain the stack.
        for (int i = 1; i <= 9; i++) call(32'(i) * 32'h100);
        for (int k = 0; k < 8; k++) begin
            set_idle();
            bus.NPCOp = 2'b11; bus.ret_addr = 32'h904 - 32'(k) * 32'h100;
            expect_val(I_TOP, 32'h904 - 32'(k) * 32'h100);
            expect_val(I_VLD, 32'd1);
            step();
        end
        set_idle();
        expect_val(I_VLD, 32'd0);
        step();
        set_idle(); bus.NPCOp = 2'b11; bus.ret_addr = 32'h123;
        step();
        set_idle();
        expect_val(I_MIS, 32'd0); expect_val(I_VLD, 32'd0);
        step();

        // Return to a different address than predicted.
        call(32'h400);
        set_idle(); bus.NPCOp = 2'b11; bus.ret_addr = 32'h500;
        expect_val(I_NPC, 32'h500);
        step();
        set_idle();
        expect_val(I_MIS, 32'd1);
        step();
        expect_val(I_MIS, 32'd0);
`ifdef NPC_PERF_CNT_EN
        expect_val(I_MCNT, 32'd1);
`endif
        step();

        // Push and pop in the same cycle replaces the top.
        call(32'h700);
        set_idle(); bus.NPCOp = 2'b11; bus.link = 1'b1; bus.PC = 32'h800; bus.ret_addr = 32'h704;
        step();
        set_idle(); bus.NPCOp = 2'b11; bus.ret_addr = 32'h804;
        expect_val(I_TOP, 32'h804); expect_val(I_VLD, 32'd1);
        step();

        // eret and exception together: eret wins, stack untouched.
        call(32'h300);
        set_idle();
        bus.MEM_eret_flush = 1'b1; bus.MEM_ex = 1'b1; bus.EPC = 32'h8000_1000;
        bus.NPCOp = 2'b11; bus.link = 1'b1;
        expect_val(I_NPC, 32'h8000_1004); expect_val(I_PFF, 32'd1); expect_val(I_STF, 32'hF);
        step();
        set_idle();
        expect_val(I_TOP, 32'h304); expect_val(I_VLD, 32'd1);
        step();

        // Asynchronous reset with a pending redirect and three entries.
        call(32'h500);
        call(32'h600);
        set_idle(); bus.MEM_ex = 1'b1; bus.PCWr = 1'b0;
        step();
        set_idle(); bus.PCWr = 1'b0;
        expect_val(I_PEND, 32'd1); expect_val(I_VLD, 32'd1);
        step();
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        expect_val(I_PEND, 32'd0); expect_val(I_VLD, 32'd0);
        expect_val(I_NPC, 32'h0000_1004);
        model_expect();
        drain();
        @(negedge clk);
        set_idle();
        rstn = 1'b1;
        @(posedge clk); #1;
        expect_val(I_NPC, 32'h0000_1004); expect_val(I_PEND, 32'd0);
        step();

        for (int n = 0; n < 400; n++) begin
            bus.PCWr           = ($urandom_range(0, 3) != 0);
            bus.NPCOp          = 2'($urandom_range(0, 3));
            bus.link           = 1'($urandom_range(0, 1));
            bus.MEM_ex         = ($urandom_range(0, 11) == 0);
            bus.MEM_eret_flush = ($urandom_range(0, 13) == 0);
            bus.PC             = {$urandom_range(0, 32'h3FFF_FFFF) , 2'b00} >> 0;
            bus.PC             = $urandom & 32'hFFFF_FFFC;
            bus.PF_PC          = $urandom & 32'hFFFF_FFFC;
            bus.Imm            = 26'($urandom);
            bus.EPC            = $urandom;
            bus.ret_addr       = ($urandom_range(0, 1) == 1 && m_stk.size() != 0) ? m_top() : $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
